// File: rtl/mips_pkg.sv
// Shared writeback encodings: load size codes, WB FSM states, datapath defaults.
// Imported by the load aligner and the commit unit.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    typedef enum logic [1:0] {
        WB_IDLE    = 2'b00,
        WB_WAIT_LD = 2'b01,
        WB_COMMIT  = 2'b10
    } wb_state_t;

    typedef struct packed {
        logic [1:0] size;
        logic       sgn;
        logic [1:0] addr_lo;
    } ld_ctl_t;

endpackage

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension, plus misalignment flag.
// Zero latency; no flow control.
module load_align
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    // Half lane uses only addr_lo[1]; the odd byte offset is dropped, not rotated.
    assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data     = rdata;
        misalign = 1'b0;
        case (size)
            LD_BYTE: data = {{(DATA_W-8){sgn & lane_b[7]}}, lane_b};
            LD_HALF: begin
                data     = {{(DATA_W-16){sgn & lane_h[15]}}, lane_h};
                misalign = addr_lo[0];
            end
            default: misalign = |addr_lo;
        endcase
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit: one registered RF write per retired instruction, 1 cycle after accept (ALU) or after load data.
// Backpressure: mem_ready drops only while a load waits for dmem_rvalid.
module wb_commit_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_is_load,
    input  logic [1:0]        mem_ld_size,
    input  logic              mem_ld_signed,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              ld_misalign,
    output logic [CNT_W-1:0]  retire_cnt
);

    wb_state_t         state;
    logic              lat_we;
    logic [REG_AW-1:0] lat_dest;
    ld_ctl_t           lat_ld;
    logic [DATA_W-1:0] al_data;
    logic              al_mis;
    logic              accept;

    assign mem_ready = (state != WB_WAIT_LD);
    assign accept    = mem_valid & mem_ready;

    assign fwd_valid = rf_we;
    assign fwd_reg   = rf_waddr;
    assign fwd_data  = rf_wdata;

    load_align #(.DATA_W(DATA_W)) u_align (
        .rdata    (dmem_rdata),
        .size     (lat_ld.size),
        .sgn      (lat_ld.sgn),
        .addr_lo  (lat_ld.addr_lo),
        .data     (al_data),
        .misalign (al_mis)
    );

    // rf_* are registered so they are stable across the whole COMMIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WB_IDLE;
            lat_we      <= 1'b0;
            lat_dest    <= '0;
            lat_ld      <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            ld_misalign <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            rf_we       <= 1'b0;
            ld_misalign <= 1'b0;
            case (state)
                WB_IDLE, WB_COMMIT: begin
                    if (accept) begin
                        if (mem_is_load) begin
                            lat_we   <= mem_reg_write;
                            lat_dest <= mem_dest;
                            lat_ld   <= '{size: mem_ld_size, sgn: mem_ld_signed, addr_lo: mem_addr_lo};
                            state    <= WB_WAIT_LD;
                        end else begin
                            state      <= WB_COMMIT;
                            retire_cnt <= retire_cnt + CNT_W'(1);
                            if (mem_reg_write && (mem_dest != '0)) begin
                                rf_we    <= 1'b1;
                                rf_waddr <= mem_dest;
                                rf_wdata <= mem_result;
                            end
                        end
                    end else begin
                        state <= WB_IDLE;
                    end
                end
                WB_WAIT_LD: begin
                    if (dmem_rvalid) begin
                        state       <= WB_COMMIT;
                        retire_cnt  <= retire_cnt + CNT_W'(1);
                        ld_misalign <= al_mis;
                        if (lat_we && (lat_dest != '0)) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= lat_dest;
                            rf_wdata <= al_data;
                        end
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule
